// File: rtl/hw_frame_acc.sv
// hw_frame_acc: collects FRAME_LEN Hamming weights per frame and hands off
// their saturating sum, maximum and minimum over a valid/ready interface.
// A held result blocks input until the consumer takes it (one bubble per frame).
module hw_frame_acc #(
  parameter int WT_W      = 5,
  parameter int FRAME_LEN = 4,
  parameter int SUM_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WT_W-1:0]  in_wt,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [WT_W-1:0]  out_max,
  output logic [WT_W-1:0]  out_min,
  output logic             out_sat
);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t            r_state;
  logic [15:0]       r_cnt;
  logic [SUM_W-1:0]  r_acc_sum;
  logic [WT_W-1:0]   r_acc_max;
  logic [WT_W-1:0]   r_acc_min;
  logic              r_acc_sat;

  logic              w_accept;
  logic [SUM_W:0]    w_sum_ext;
  logic [SUM_W-1:0]  w_sum_next;
  logic              w_sat_next;
  logic [WT_W-1:0]   w_max_next;
  logic [WT_W-1:0]   w_min_next;

  // The running sum never exceeds 2^SUM_W-1 and a weight fits in SUM_W bits,
  // so an overflow can only ever show up in the extra top bit.
  function automatic logic [SUM_W-1:0] sat_clamp(input logic [SUM_W:0] v);
    return v[SUM_W] ? {SUM_W{1'b1}} : v[SUM_W-1:0];
  endfunction

  assign in_ready   = (r_state == ACC);
  assign w_accept   = in_valid & in_ready & ~abort;

  assign w_sum_ext  = {1'b0, r_acc_sum} + {{(SUM_W + 1 - WT_W){1'b0}}, in_wt};
  assign w_sum_next = sat_clamp(w_sum_ext);
  assign w_sat_next = r_acc_sat | w_sum_ext[SUM_W];
  assign w_max_next = (in_wt > r_acc_max) ? in_wt : r_acc_max;
  assign w_min_next = (in_wt < r_acc_min) ? in_wt : r_acc_min;

  // Frame FSM: accumulate in ACC, hold the registered result in DONE until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ACC;
      r_cnt     <= '0;
      r_acc_sum <= '0;
      r_acc_max <= '0;
      r_acc_min <= '1;
      r_acc_sat <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_max   <= '0;
      out_min   <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (r_state)
        ACC: begin
          if (abort) begin
            r_cnt     <= '0;
            r_acc_sum <= '0;
            r_acc_max <= '0;
            r_acc_min <= '1;
            r_acc_sat <= 1'b0;
          end else if (w_accept) begin
            if (r_cnt == LAST_IDX) begin
              // Last word of the frame: publish including this word, rearm accumulators.
              out_sum   <= w_sum_next;
              out_max   <= w_max_next;
              out_min   <= w_min_next;
              out_sat   <= w_sat_next;
              out_valid <= 1'b1;
              r_state   <= DONE;
              r_cnt     <= '0;
              r_acc_sum <= '0;
              r_acc_max <= '0;
              r_acc_min <= '1;
              r_acc_sat <= 1'b0;
            end else begin
              r_cnt     <= r_cnt + 16'd1;
              r_acc_sum <= w_sum_next;
              r_acc_max <= w_max_next;
              r_acc_min <= w_min_next;
              r_acc_sat <= w_sat_next;
            end
          end
        end
        DONE: begin
          // abort is deliberately ignored here so a finished result is never lost.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_hw_frame_acc.sv
// Testbench for hw_frame_acc: three instances (defaults, SUM_W=6, FRAME_LEN=1)
// share one stimulus stream and are compared every cycle against a frame-level
// reference model, plus directed checks of the documented scenarios.
module tb_hw_frame_acc;

  logic clk;
  logic rst, in_valid, abort, out_ready;
  logic [4:0] in_wt;

  logic        rdy0, vld0, sat0;
  logic [15:0] sum0;
  logic [4:0]  max0, min0;
  logic        rdy1, vld1, sat1;
  logic [5:0]  sum1;
  logic [4:0]  max1, min1;
  logic        rdy2, vld2, sat2;
  logic [15:0] sum2;
  logic [4:0]  max2, min2;

  int n_chk  = 0;
  int n_fail = 0;

  hw_frame_acc #(.WT_W(5), .FRAME_LEN(4), .SUM_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_wt(in_wt),
    .abort(abort), .out_valid(vld0), .out_ready(out_ready), .out_sum(sum0),
    .out_max(max0), .out_min(min0), .out_sat(sat0));

  hw_frame_acc #(.WT_W(5), .FRAME_LEN(4), .SUM_W(6)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_wt(in_wt),
    .abort(abort), .out_valid(vld1), .out_ready(out_ready), .out_sum(sum1),
    .out_max(max1), .out_min(min1), .out_sat(sat1));

  hw_frame_acc #(.WT_W(5), .FRAME_LEN(1), .SUM_W(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_wt(in_wt),
    .abort(abort), .out_valid(vld2), .out_ready(out_ready), .out_sum(sum2),
    .out_max(max2), .out_min(min2), .out_sat(sat2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, the words of the open frame and the last published result.
  int     fl [3] = '{4, 4, 1};
  int     sw [3] = '{16, 6, 16};
  int     nw [3];
  int     words [3][16];
  bit     pend [3];
  longint e_sum [3];
  int     e_max [3];
  int     e_min [3];
  bit     e_sat [3];
  bit     started = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    longint s, lim;
    int mx, mn;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        nw[k] = 0; pend[k] = 0;
        e_sum[k] = 0; e_max[k] = 0; e_min[k] = 0; e_sat[k] = 0;
      end else if (pend[k]) begin
        if (out_ready) pend[k] = 0;
      end else if (abort) begin
        nw[k] = 0;
      end else if (in_valid) begin
        words[k][nw[k]] = int'(in_wt);
        nw[k]++;
        if (nw[k] == fl[k]) begin
          s = 0; mx = 0; mn = 31;
          for (int i = 0; i < fl[k]; i++) begin
            s += words[k][i];
            if (words[k][i] > mx) mx = words[k][i];
            if (words[k][i] < mn) mn = words[k][i];
          end
          lim = (longint'(1) << sw[k]) - 1;
          e_sat[k] = (s > lim);
          e_sum[k] = (s > lim) ? lim : s;
          e_max[k] = mx;
          e_min[k] = mn;
          pend[k]  = 1;
          nw[k]    = 0;
        end
      end
    end
    if (rst) started = 1'b1;
  endtask

  task automatic check_dut(input int k);
    logic v, r, st;
    logic [15:0] s;
    logic [4:0] mx, mn;
    case (k)
      0: begin v = vld0; r = rdy0; s = sum0; mx = max0; mn = min0; st = sat0; end
      1: begin v = vld1; r = rdy1; s = {10'd0, sum1}; mx = max1; mn = min1; st = sat1; end
      default: begin v = vld2; r = rdy2; s = sum2; mx = max2; mn = min2; st = sat2; end
    endcase
    chk($sformatf("u%0d out_valid", k), 64'(v), 64'(pend[k]));
    chk($sformatf("u%0d in_ready", k), 64'(r), 64'(!pend[k]));
    chk($sformatf("u%0d out_sum", k), 64'(s), 64'(e_sum[k]));
    chk($sformatf("u%0d out_max", k), 64'(mx), 64'(e_max[k]));
    chk($sformatf("u%0d out_min", k), 64'(mn), 64'(e_min[k]));
    chk($sformatf("u%0d out_sat", k), 64'(st), 64'(e_sat[k]));
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic cyc(input logic v, input logic [4:0] w, input logic ab,
                     input logic ordy, input logic r);
    in_valid = v; in_wt = w; abort = ab; out_ready = ordy; rst = r;
    model_step();
    @(negedge clk);
    if (started) for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  task automatic feed(input logic [4:0] w, input logic ordy);
    cyc(1'b1, w, 1'b0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wt = '0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    do_reset();
    chk("reset out_valid", 64'(vld0), 64'd0);
    chk("reset in_ready", 64'(rdy0), 64'd1);
    chk("reset out_sum", 64'(sum0), 64'd0);

    // Defaults: 3,7,0,31
    feed(5'd3, 1'b0); feed(5'd7, 1'b0); feed(5'd0, 1'b0); feed(5'd31, 1'b0);
    chk("t1 out_valid", 64'(vld0), 64'd1);
    chk("t1 sum", 64'(sum0), 64'd41);
    chk("t1 max", 64'(max0), 64'd31);
    chk("t1 min", 64'(min0), 64'd0);
    chk("t1 sat", 64'(sat0), 64'd0);
    chk("t1 in_ready", 64'(rdy0), 64'd0);

    // Backpressure: 10 cycles of offered words while the result is held
    for (int i = 0; i < 10; i++) feed(5'd5, 1'b0);
    chk("t2 held sum", 64'(sum0), 64'd41);
    chk("t2 held valid", 64'(vld0), 64'd1);
    feed(5'd5, 1'b1);
    chk("t2 in_ready after hs", 64'(rdy0), 64'd1);
    chk("t2 valid after hs", 64'(vld0), 64'd0);

    // Saturation on the SUM_W=6 instance
    do_reset();
    feed(5'd31, 1'b0); feed(5'd31, 1'b0); feed(5'd31, 1'b0); feed(5'd1, 1'b0);
    chk("t3 sum", 64'(sum1), 64'd63);
    chk("t3 sat", 64'(sat1), 64'd1);
    chk("t3 max", 64'(max1), 64'd31);
    chk("t3 min", 64'(min1), 64'd1);
    chk("t3 wide sum", 64'(sum0), 64'd94);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) feed(5'd1, 1'b0);
    chk("t3 next sum", 64'(sum1), 64'd4);
    chk("t3 next sat", 64'(sat1), 64'd0);

    // Abort
    do_reset();
    feed(5'd9, 1'b0); feed(5'd9, 1'b0);
    cyc(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    feed(5'd2, 1'b0); feed(5'd4, 1'b0); feed(5'd6, 1'b0); feed(5'd8, 1'b0);
    chk("t4 valid", 64'(vld0), 64'd1);
    chk("t4 sum", 64'(sum0), 64'd20);
    chk("t4 max", 64'(max0), 64'd8);
    chk("t4 min", 64'(min0), 64'd2);

    // Reset mid-frame and while holding a result
    do_reset();
    feed(5'd5, 1'b0); feed(5'd5, 1'b0);
    do_reset();
    chk("t5 mid valid", 64'(vld0), 64'd0);
    chk("t5 mid ready", 64'(rdy0), 64'd1);
    feed(5'd1, 1'b0); feed(5'd2, 1'b0); feed(5'd3, 1'b0); feed(5'd4, 1'b0);
    chk("t5 fresh sum", 64'(sum0), 64'd10);
    do_reset();
    chk("t5 done valid", 64'(vld0), 64'd0);
    chk("t5 done ready", 64'(rdy0), 64'd1);
    for (int i = 0; i < 4; i++) feed(5'd4, 1'b0);
    chk("t5 fresh2 sum", 64'(sum0), 64'd16);

    // FRAME_LEN=1 instance
    do_reset();
    feed(5'd12, 1'b0);
    chk("t6 a valid", 64'(vld2), 64'd1);
    chk("t6 a sum", 64'(sum2), 64'd12);
    chk("t6 a max", 64'(max2), 64'd12);
    chk("t6 a min", 64'(min2), 64'd12);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    feed(5'd0, 1'b0);
    chk("t6 b valid", 64'(vld2), 64'd1);
    chk("t6 b sum", 64'(sum2), 64'd0);
    chk("t6 b max", 64'(max2), 64'd0);
    chk("t6 b min", 64'(min2), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
